serial_receiver: RTL and testbench



---
 rtl/serial_pkg.sv | 27 ++
 rtl/serial_rx_fifo.sv | 60 ++++++
 rtl/serial_receiver.sv | 202 ++++++++++++++++++++
 tb/tb_serial_receiver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Brief    : Shared types and constants for the UART receive path and the
//            data-memory IO window. Optional build macro: RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam int          SERIAL_DATA_BITS = 8;
    localparam logic [31:0] IO_ADDRESS_LOW   = 32'h0002_fff0;
    localparam logic [31:0] IO_ADDRESS_HIGH  = 32'h0002_ffff;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
`ifdef RX_PARITY_EN
        ,
        PARITY    = 3'd5
`endif
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_fifo
// Brief    : Show-ahead receive byte buffer; a push into a full FIFO is only
//            accepted when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int              c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_full);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    // Empty FIFO presents zero so the head matches the reset value.
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/serial_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_receiver
// Brief    : UART 8N1 receiver (8E1 when RX_PARITY_EN is defined) feeding a
//            show-ahead byte FIFO with sticky overrun/framing/parity flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_receiver
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_available,
    input  logic       rx_data_taken,
    output logic       rx_overrun,
    output logic       rx_frame_error,
`ifdef RX_PARITY_EN
    output logic       rx_parity_error,
`endif
    input  logic       rx_clear_errors
);

    localparam int                 c_baud_w  = $clog2(CLKS_PER_BIT);
    localparam int                 c_bit_w   = $clog2(SERIAL_DATA_BITS);
    localparam logic [c_baud_w-1:0] c_bit_end  = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_half_end = c_baud_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_bit_w-1:0]  c_last_bit = c_bit_w'(SERIAL_DATA_BITS - 1);

    logic                        r_rxd_meta;
    logic                        r_rxd_s;
    rx_state_t                   r_state,  w_state_nxt;
    logic [c_baud_w-1:0]         r_baud,   w_baud_nxt;
    logic [c_bit_w-1:0]          r_bit,    w_bit_nxt;
    logic [SERIAL_DATA_BITS-1:0] r_shift,  w_shift_nxt;
    logic                        w_tick;
    logic                        w_push;
    logic                        w_frame_err_set;
    logic                        w_overrun_set;
    logic                        w_full;
    logic                        w_empty;
`ifdef RX_PARITY_EN
    logic                        r_par_bad, w_par_bad_nxt;
    logic                        w_par_err_set;
    logic                        r_parity_error;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= serial_rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
`ifdef RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
`ifdef RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    assign w_tick = (r_baud == c_bit_end);

    always_comb begin
        w_state_nxt     = r_state;
        w_baud_nxt      = r_baud + 1'b1;
        w_bit_nxt       = r_bit;
        w_shift_nxt     = r_shift;
        w_push          = 1'b0;
        w_frame_err_set = 1'b0;
`ifdef RX_PARITY_EN
        w_par_bad_nxt   = r_par_bad;
        w_par_err_set   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (!r_rxd_s) w_state_nxt = START;
            end
            START: begin
                // Mid-start-bit recheck rejects short glitches on the line.
                if (r_baud == c_half_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = r_rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {r_rxd_s, r_shift[SERIAL_DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == c_last_bit) begin
`ifdef RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_baud_nxt    = '0;
                    w_par_bad_nxt = r_rxd_s ^ (^r_shift);
                    w_state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_baud_nxt = '0;
`ifdef RX_PARITY_EN
                    w_par_err_set = r_par_bad;
`endif
                    if (r_rxd_s) begin
`ifdef RX_PARITY_EN
                        w_push = !r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err_set = 1'b1;
                        w_state_nxt     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                w_baud_nxt = '0;
                if (r_rxd_s) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // A full FIFO only has a free slot if the head leaves in the same cycle.
    assign w_overrun_set = w_push && w_full && !rx_data_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun     <= 1'b0;
            rx_frame_error <= 1'b0;
        end else begin
            if (w_overrun_set)        rx_overrun <= 1'b1;
            else if (rx_clear_errors) rx_overrun <= 1'b0;
            if (w_frame_err_set)      rx_frame_error <= 1'b1;
            else if (rx_clear_errors) rx_frame_error <= 1'b0;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                r_parity_error <= 1'b0;
        else if (w_par_err_set)   r_parity_error <= 1'b1;
        else if (rx_clear_errors) r_parity_error <= 1'b0;
    end
    assign rx_parity_error = r_parity_error;
`endif

    serial_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (SERIAL_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (rx_data_taken),
        .head      (rx_data),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign rx_data_available = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serial_receiver
// Brief    : Directed self-checking bench for serial_receiver (16 clk/bit, 4-deep FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_receiver;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_rxd;
    logic [7:0] rx_data;
    logic       rx_data_available;
    logic       rx_data_taken;
    logic       rx_overrun;
    logic       rx_frame_error;
    logic       rx_clear_errors;
`ifdef RX_PARITY_EN
    logic       rx_parity_error;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_receiver #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .serial_rxd        (serial_rxd),
        .rx_data           (rx_data),
        .rx_data_available (rx_data_available),
        .rx_data_taken     (rx_data_taken),
        .rx_overrun        (rx_overrun),
        .rx_frame_error    (rx_frame_error),
`ifdef RX_PARITY_EN
        .rx_parity_error   (rx_parity_error),
`endif
        .rx_clear_errors   (rx_clear_errors)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_rxd = b;
        tick(CPB);
    endtask

    // Stop bit is sampled on the 11th edge into it; the byte is visible after that edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic pop_at_push, input logic check_latency);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit(^d);
`endif
        serial_rxd = stop_bit;
        tick(CPB - 6);
        if (check_latency) check1("latency_before_push", rx_data_available, 1'b0);
        rx_data_taken = pop_at_push;
        tick(1);
        rx_data_taken = 1'b0;
        if (check_latency) begin
            check1("latency_avail", rx_data_available, 1'b1);
            check8("latency_data", rx_data, d);
        end
        tick(5);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        check1(tag, rx_data_available, 1'b1);
        check8(tag, rx_data, d);
        rx_data_taken = 1'b1;
        tick(1);
        rx_data_taken = 1'b0;
    endtask

    task automatic clear_flags();
        rx_clear_errors = 1'b1;
        tick(1);
        rx_clear_errors = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        serial_rxd      = 1'b1;
        rx_data_taken   = 1'b0;
        rx_clear_errors = 1'b0;
        tick(3);
        check8("reset_data", rx_data, 8'h00);
        check1("reset_avail", rx_data_available, 1'b0);
        check1("reset_overrun", rx_overrun, 1'b0);
        check1("reset_frame", rx_frame_error, 1'b0);
        reset = 1'b0;
        tick(5);

        // Single frame with latency check, then pop.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        pop_expect("a5_pop", 8'hA5);
        check1("a5_empty", rx_data_available, 1'b0);

        // Short low glitch must be rejected.
        serial_rxd = 1'b0;
        tick(4);
        serial_rxd = 1'b1;
        tick(40);
        check1("glitch_avail", rx_data_available, 1'b0);
        check1("glitch_frame", rx_frame_error, 1'b0);
        check1("glitch_overrun", rx_overrun, 1'b0);

        // Overrun: five frames into a four-entry FIFO.
        for (int k = 1; k <= 5; k++) begin
            send_frame(k[7:0], 1'b1, 1'b0, 1'b0);
            if (k == 4) check1("fill4_no_overrun", rx_overrun, 1'b0);
        end
        check1("overrun_set", rx_overrun, 1'b1);
        for (int k = 1; k <= 4; k++) pop_expect("overrun_drain", k[7:0]);
        check1("overrun_empty", rx_data_available, 1'b0);
        check1("overrun_sticky", rx_overrun, 1'b1);
        clear_flags();
        check1("overrun_cleared", rx_overrun, 1'b0);

        // Push and pop in the same cycle while full.
        for (int k = 1; k <= 4; k++) send_frame(k[7:0], 1'b1, 1'b0, 1'b0);
        send_frame(8'h05, 1'b1, 1'b1, 1'b0);
        check1("full_pushpop_no_overrun", rx_overrun, 1'b0);
        for (int k = 2; k <= 5; k++) pop_expect("pushpop_drain", k[7:0]);
        check1("pushpop_empty", rx_data_available, 1'b0);

        // Framing error with break, then recovery.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(40);
        serial_rxd = 1'b1;
        check1("frame_err_set", rx_frame_error, 1'b1);
        check1("frame_err_no_push", rx_data_available, 1'b0);
        tick(20);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        pop_expect("after_err_7e", 8'h7E);
        check1("frame_err_sticky", rx_frame_error, 1'b1);
        clear_flags();
        check1("frame_err_cleared", rx_frame_error, 1'b0);

        // Reset mid-frame with a flag set and a byte buffered.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        serial_rxd = 1'b1;
        tick(20);
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        check1("pre_reset_frame", rx_frame_error, 1'b1);
        check1("pre_reset_avail", rx_data_available, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        #2;
        check8("midreset_data", rx_data, 8'h00);
        check1("midreset_avail", rx_data_available, 1'b0);
        check1("midreset_frame", rx_frame_error, 1'b0);
        check1("midreset_overrun", rx_overrun, 1'b0);
        tick(3);
        reset = 1'b0;
        tick(5);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        pop_expect("post_reset_12", 8'h12);
        check1("post_reset_empty", rx_data_available, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
